// File: rtl/bin2bcd_convert_module.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional build macro BIN2BCD_SATURATE_EN clamps captured values above 999 to 999.
module bin2bcd_convert_module #(
    parameter int BIN_W = 10
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start_Sig,
    input  logic [BIN_W-1:0] Bin_Data,
    output logic [11:0]      Number_Sig,
    output logic             Done_Sig,
    output logic             Busy_Sig,
    output logic             Ovf_Sig,
    output logic [1:0]       state_dbg
);
    // Handshake: Start_Sig is taken at a rising edge only while Busy_Sig is low (never queued);
    // Done_Sig pulses once, BIN_W+2 edges later, in the cycle Number_Sig/Ovf_Sig take the new result.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [BIN_W-1:0] shift_q;
    logic [11:0]      acc_q;
    logic [11:0]      acc_adj;
    logic [3:0]       cnt_q;
    logic             ovf_q;
    logic             ovf_in;
    logic [BIN_W-1:0] load_val;

    assign state_dbg = state;

    // Only a 10-bit input can exceed 999; narrower widths leave this constant 0.
    assign ovf_in = (32'(Bin_Data) > 32'd999);

`ifdef BIN2BCD_SATURATE_EN
    assign load_val = ovf_in ? BIN_W'(32'd999) : Bin_Data;
`else
    assign load_val = Bin_Data;
`endif

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            Number_Sig <= 12'h000;
            Done_Sig   <= 1'b0;
            Busy_Sig   <= 1'b0;
            Ovf_Sig    <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start_Sig) begin
                        shift_q  <= load_val;
                        ovf_q    <= ovf_in;
                        Busy_Sig <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q <= '0;
                    cnt_q <= 4'(BIN_W);
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // The thousands carry (acc_adj[11]) falls off the top here.
                    acc_q   <= {acc_adj[10:0], shift_q[BIN_W-1]};
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Number_Sig <= acc_q;
                    Ovf_Sig    <= ovf_q;
                    Done_Sig   <= 1'b1;
                    Busy_Sig   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_convert_module.sv
// Self-checking bench for bin2bcd_convert_module: arithmetic reference model, expected queue, negedge monitor.
module tb_bin2bcd_convert_module;
    localparam int BIN_W = 10;
    localparam int LAT   = BIN_W + 2;
    localparam int QW    = 45;   // {due_cycle[31:0], ovf, bcd[11:0]}

    logic             CLK;
    logic             RSTn;
    logic             Start_Sig;
    logic [BIN_W-1:0] Bin_Data;
    logic [11:0]      Number_Sig;
    logic             Done_Sig;
    logic             Busy_Sig;
    logic             Ovf_Sig;
    logic [1:0]       state_dbg;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int busy_until = 0;
    int next_free  = 0;
    int done_cnt   = 0;
    logic [12:0]   last_out = '0;
    logic [QW-1:0] exp_q[$];

    bin2bcd_convert_module #(.BIN_W(BIN_W)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Start_Sig  (Start_Sig),
        .Bin_Data   (Bin_Data),
        .Number_Sig (Number_Sig),
        .Done_Sig   (Done_Sig),
        .Busy_Sig   (Busy_Sig),
        .Ovf_Sig    (Ovf_Sig),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // reference model: decimal digits by plain arithmetic
    function automatic logic [11:0] model_bcd(input int v);
        int x;
        x = v;
`ifdef BIN2BCD_SATURATE_EN
        if (x > 999) x = 999;
`endif
        x = x % 1000;
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
        return (v > 999);
    endfunction

    // acceptance model: a start is taken when the previous job has fully retired
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (!RSTn) begin
            exp_q.delete();
            busy_until = 0;
            next_free  = 0;
        end else if (Start_Sig && cyc >= next_free) begin
            exp_q.push_back({32'(cyc + LAT), model_ovf(int'(Bin_Data)), model_bcd(int'(Bin_Data))});
            busy_until = cyc + LAT;
            next_free  = cyc + LAT + 1;
        end
    end

    // monitor
    always @(negedge CLK) begin
        logic [QW-1:0] e;
        if (!RSTn) begin
            last_out = '0;
        end else begin
            checks++;
            if (Busy_Sig !== (cyc < busy_until)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, Busy_Sig, (cyc < busy_until));
            end
            if (Done_Sig) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got=%h", cyc, Number_Sig);
                end else begin
                    e = exp_q.pop_front();
                    if (Number_Sig !== e[11:0] || Ovf_Sig !== e[12] || cyc != int'(e[44:13])) begin
                        errors++;
                        $display("FAIL result cyc=%0d got num=%h ovf=%b exp num=%h ovf=%b due=%0d",
                                 cyc, Number_Sig, Ovf_Sig, e[11:0], e[12], int'(e[44:13]));
                    end
                end
            end else begin
                checks++;
                if ({Ovf_Sig, Number_Sig} !== last_out) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, {Ovf_Sig, Number_Sig}, last_out);
                end
            end
            last_out = {Ovf_Sig, Number_Sig};
        end
    end

    // driver tasks
    task automatic check_idle_outputs(input string name);
        checks++;
        if (Number_Sig !== 12'h000 || Done_Sig !== 1'b0 || Busy_Sig !== 1'b0 || Ovf_Sig !== 1'b0) begin
            errors++;
            $display("FAIL %s got num=%h done=%b busy=%b ovf=%b exp all zero",
                     name, Number_Sig, Done_Sig, Busy_Sig, Ovf_Sig);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic do_conv(input logic [BIN_W-1:0] v);
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = v;
        @(negedge CLK);
        Start_Sig = 1'b0;
        Bin_Data  = BIN_W'($urandom_range(0, 1023));
        wait_drain(40);
    endtask

    initial begin
        int d0;
        RSTn      = 1'b0;
        Start_Sig = 1'b0;
        Bin_Data  = '0;
        repeat (4) @(negedge CLK);
        #2 RSTn = 1'b1;

        // reset state and idle
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1 check_idle_outputs("idle");
        end

        // directed values including the overflow range
        do_conv(10'd0);
        do_conv(10'd255);
        do_conv(10'd999);
        do_conv(10'd1023);
        do_conv(10'd1000);

        // starts during a conversion are ignored
        d0 = done_cnt;
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 10'd123;
        @(negedge CLK);                      // conversion cycle 1
        Start_Sig = 1'b0;
        Bin_Data  = 10'd456;
        repeat (2) @(negedge CLK);           // cycle 3
        Start_Sig = 1'b1;
        @(negedge CLK);
        Start_Sig = 1'b0;
        repeat (4) @(negedge CLK);           // cycle 8
        Start_Sig = 1'b1;
        @(negedge CLK);
        Start_Sig = 1'b0;
        wait_drain(40);
        repeat (2) @(negedge CLK);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ignore_start done_pulses got=%0d exp=1", done_cnt - d0);
        end

        // Start held high: back-to-back conversions
        d0 = done_cnt;
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 10'd500;
        repeat (40) @(negedge CLK);
        Start_Sig = 1'b0;
        wait_drain(40);
        repeat (2) @(negedge CLK);
        checks++;
        if (done_cnt - d0 != 4) begin
            errors++;
            $display("FAIL back_to_back done_pulses got=%0d exp=4", done_cnt - d0);
        end

        // reset in the middle of a conversion
        do_conv(10'd321);
        d0 = done_cnt;
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 10'd654;
        @(negedge CLK);
        Start_Sig = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1 check_idle_outputs("reset_immediate");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1 check_idle_outputs("reset_hold");
        end
        #1 RSTn = 1'b1;
        repeat (15) @(negedge CLK);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abandoned_done got=%0d exp=0", done_cnt - d0);
        end
        do_conv(10'd654);

        // random values across the full input range
        for (int i = 0; i < 20; i++) begin
            do_conv(BIN_W'($urandom_range(0, 1023)));
        end

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_convert_module.md
Name: bin2bcd_convert_module

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the 3-digit seven-segment interface. It converts a binary count (sensor value, counter, etc.) into the 12-bit packed BCD Number_Sig that the display interface consumes. The output register holds its value between conversions, so the display never sees intermediate values.

Parameters:
BIN_W, 10, binary input width; legal range 4..10. Latency and iteration count scale with it.

Ports:
CLK  input  1  system clock
RSTn  input  1  reset, asynchronous, active-low
Start_Sig  input  1  conversion request; sampled only in IDLE
Bin_Data  input  BIN_W  binary value to convert; captured on the accepted Start_Sig edge
Number_Sig  output  12  packed BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones; feeds the display interface
Done_Sig  output  1  one-cycle pulse when Number_Sig has just been updated
Busy_Sig  output  1  high while a conversion is in progress
Ovf_Sig  output  1  registered with the result; 1 if the captured value was greater than 999

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTn is asynchronous and active-low.
- Reset values:
  - Number_Sig = 12'h000
  - Done_Sig = 0, Busy_Sig = 0, Ovf_Sig = 0
  - FSM = IDLE; internal shift and BCD registers cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Start_Sig = 1 at a rising edge moves the FSM to LOAD and captures Bin_Data into the shift register.
  - Ovf is computed from the captured value (> 999).
  - Busy_Sig goes high on that same edge.
- LOAD: clears the 12-bit BCD accumulator and sets the iteration counter to BIN_W. Moves to SHIFT.
- SHIFT, one iteration per cycle, BIN_W cycles total:
  - For each BCD nibble >= 5, add 3 to that nibble.
  - Then shift {accumulator, shift register} left by 1.
  - Decrement the counter; leave SHIFT after the iteration where the counter reaches 1.
- DONE:
  - Number_Sig <= accumulator, Ovf_Sig <= captured overflow flag.
  - Done_Sig = 1 for exactly this one cycle; Busy_Sig drops on the edge leaving DONE. Return to IDLE.
- Latency: Done_Sig is high in the cycle that begins BIN_W+2 rising edges after the edge that accepted Start_Sig. That is 12 edges for BIN_W = 10.
- Number_Sig changes only on entry to DONE; it is stable at all other times.
- Start_Sig while Busy_Sig = 1 (LOAD/SHIFT/DONE) is ignored, not queued.
- Start_Sig held high continuously gives back-to-back conversions, one every BIN_W+3 cycles (IDLE revisited for one cycle).
- Bin_Data may change freely after the accepting edge.
- Accumulator width is 12 bits. Any thousands carry is discarded unless the optional feature is compiled in.
- RSTn asserted mid-conversion:
  - All outputs return immediately to their reset values.
  - The conversion is abandoned; no Done_Sig pulse.
- Ovf_Sig is meaningful only when BIN_W = 10; for smaller widths it is constant 0.

Optional Feature:
Macro BIN2BCD_SATURATE_EN.
- Defined: a captured value > 999 is replaced by 999 before conversion, so Number_Sig = 12'h999 and Ovf_Sig = 1.
- Undefined: the raw value is converted and the thousands carry is dropped. For 1000..1023, Number_Sig = value − 1000 in BCD (e.g. 1023 → 12'h023), and Ovf_Sig = 1.
- Latency is identical in both builds.

Test Plan:
- Reset then idle 20 cycles → Number_Sig = 12'h000, Done_Sig / Busy_Sig / Ovf_Sig = 0 throughout.
- Start with Bin_Data = 0, 255, 999 in turn:
  - Number_Sig = 12'h000, 12'h255, 12'h999 respectively.
  - Done_Sig pulses exactly 12 edges after each start; Ovf_Sig = 0.
- Start with Bin_Data = 1023:
  - With BIN2BCD_SATURATE_EN: Number_Sig = 12'h999, Ovf_Sig = 1.
  - Without the macro: Number_Sig = 12'h023, Ovf_Sig = 1.
- Start with 123, then pulse Start with 456 at cycles 3 and 8 of that conversion:
  - Only 12'h123 is produced; one Done_Sig pulse.
  - The Bin_Data change after acceptance has no effect.
- Start with 500 and hold Start_Sig high for 40 cycles with Bin_Data = 500:
  - Done_Sig pulses every 13 cycles.
  - Number_Sig = 12'h500, never an intermediate value.
- Complete a conversion of 321, then start 654 and assert RSTn low at SHIFT cycle 5:
  - Number_Sig = 12'h000 and Busy_Sig = 0 immediately, no Done_Sig pulse.
  - After release, a new start of 654 yields 12'h654.
